baser_rx_block_sync: RTL and testbench
======================================

// Module: baser_rx_block_sync
// PURPOSE
//  10GBASE-R receive block-lock stage (IEEE 802.3 cl.49.2.14) between SERDES gearbox and xgmii_baser_dec_64.
//  Checks 2-bit sync headers, requests SERDES bitslip until lock, reports lock, registers block to decoder.
//  Outputs encoded_rx_data/encoded_rx_hdr connect directly to the decoder inputs of the same names.
// PARAMETERS
//  DATA_WIDTH      64  block payload width; only 64 supported
//  HDR_WIDTH       2   sync header width; only 2 supported
//  SLIP_HOLD       8   cycles header checking is suspended after a bitslip pulse (1..255)
// PORTS
//  clk                 in   1           block clock
//  rst                 in   1           asynchronous reset, active-high
//  serdes_rx_data      in   DATA_WIDTH  raw block payload from gearbox, bit 0 first on line
//  serdes_rx_hdr       in   HDR_WIDTH   raw sync header from gearbox
//  serdes_rx_bitslip   out  1           one-cycle slip request to gearbox
//  encoded_rx_data     out  DATA_WIDTH  block payload to decoder
//  encoded_rx_hdr      out  HDR_WIDTH   sync header to decoder
//  rx_block_lock       out  1           1 = block lock acquired
//  rx_sh_invalid       out  1           one-cycle pulse per invalid header checked
// BEHAVIOUR
//  - Reset (async, any time incl. mid-slip): all outputs 0; state SEARCH; sh_cnt=0, bad_cnt=0, hold_cnt=0.
//  - Header valid iff serdes_rx_hdr==2'b01 or 2'b10. encoded_rx_* = serdes_rx_* delayed 1 clk, always,
//    regardless of lock. rx_sh_invalid registered with same 1-clk latency, only for checked headers.
//  - sh_cnt 6-bit (0..63), bad_cnt 5-bit (0..16), hold_cnt 8-bit.
//  - SEARCH: valid hdr -> sh_cnt++; at valid hdr with sh_cnt==63 -> rx_block_lock=1, counters 0, go LOCKED
//    (lock rises on cycle after 64th consecutive valid hdr). Invalid hdr -> serdes_rx_bitslip=1 next cycle,
//    counters 0, hold_cnt=SLIP_HOLD, go SLIP.
//  - SLIP: bitslip high exactly one cycle; headers ignored (no count, no rx_sh_invalid); hold_cnt-- each cycle;
//    at 0 -> SEARCH. rx_block_lock stays 0.
//  - LOCKED: every hdr -> sh_cnt++ (64-hdr window); invalid -> bad_cnt++.
//    Invalid hdr making bad_cnt==16 -> rx_block_lock=0 and bitslip pulse next cycle, counters 0, go SLIP
//    (takes priority over window end). Else at sh_cnt==63 -> sh_cnt=0, bad_cnt=0 (window wraps; hdr of
//    the 64th slot counted in closing window).
//  - sh_cnt wraps 63->0 only via explicit clears; no overflow paths.
// CONFIGURATION
//  BASER_RX_DESCRAMBLE_EN defined: self-synchronising descrambler 1+x^39+x^58 on payload; for bit i,
//    out[i]=in[i]^s[38]^s[57], s=history of last 58 received scrambled bits (LSB first); s resets to
//    all-ones; runs regardless of lock; header never descrambled; latency stays 1 clk.
//  Not defined: encoded_rx_data is raw serdes_rx_data delayed 1 clk, no descrambler logic.
// TESTING
//  1. Assert rst mid-stream -> all outputs 0 immediately; after release, lock requires fresh 64 valid hdrs.
//  2. 64 hdrs 2'b01 from reset -> rx_block_lock=0 through 64th hdr, =1 on following cycle; no bitslip.
//  3. SEARCH, hdr 2'b00 -> bitslip=1 one cycle, rx_sh_invalid=1; next 8 hdrs 2'b11 -> no pulses; 9th checked.
//  4. LOCKED, 15 hdr 2'b11 in one 64-hdr window -> lock held; 16th in same window -> lock=0 + one bitslip.
//  5. LOCKED, 15 invalid in each of 3 consecutive windows -> lock held, bad_cnt clears at each boundary.
//  6. With BASER_RX_DESCRAMBLE_EN: scrambled idle blocks (hdr 2'b10, descrambled 0x000000000000001E) after
//     1 warm-up block -> encoded_rx_data=64'h1E; without macro -> output equals input delayed 1 clk.

Source files
------------

// File: rtl/baser_rx_block_sync.sv
// rtl/baser_rx_block_sync.sv - 10GBASE-R receive block lock with bitslip control
//
// Sits between the SERDES gearbox and the 64b/66b decoder. It checks the 2-bit
// sync headers, asks the gearbox to slip until 64 consecutive valid headers are
// seen, then monitors 64-header windows and drops lock after 16 bad headers in
// one window.
//
// Optional feature macro: BASER_RX_DESCRAMBLE_EN
//   defined   - payload passes through a self-synchronising 1+x^39+x^58 descrambler
//   undefined - payload is passed through unchanged
//
// Ports:
//   clk                in   block clock
//   rst                in   asynchronous reset, active-high
//   serdes_rx_data     in   raw block payload from gearbox, bit 0 first on line
//   serdes_rx_hdr      in   raw sync header from gearbox
//   serdes_rx_bitslip  out  one-cycle slip request to gearbox
//   encoded_rx_data    out  block payload to decoder (1 clk latency)
//   encoded_rx_hdr     out  sync header to decoder (1 clk latency)
//   rx_block_lock      out  1 = block lock acquired
//   rx_sh_invalid      out  one-cycle pulse per invalid header checked

module baser_rx_block_sync #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int SLIP_HOLD  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] encoded_rx_data,
    output logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    output logic                  rx_block_lock,
    output logic                  rx_sh_invalid
);

    localparam logic [7:0] HOLD_INIT = 8'(SLIP_HOLD);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state, state_next;

    logic [5:0] sh_cnt, sh_cnt_next;
    logic [4:0] bad_cnt, bad_cnt_next;
    logic [7:0] hold_cnt, hold_cnt_next;
    logic       bitslip_next;
    logic       lock_next;
    logic       invalid_next;
    logic       hdr_valid;

    logic [DATA_WIDTH-1:0] data_next;

    assign hdr_valid = (serdes_rx_hdr == 2'b01) || (serdes_rx_hdr == 2'b10);

`ifdef BASER_RX_DESCRAMBLE_EN
    // hist[57] is the most recently received scrambled bit, hist[0] the oldest.
    // Concatenating the new block above it puts line bit i at full[58+i], so the
    // taps 39 and 58 bits back land at full[i+19] and full[i].
    logic [57:0]              hist;
    logic [DATA_WIDTH+57:0]   full;

    always_comb begin
        full = {serdes_rx_data, hist};
        data_next = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_next[i] = full[58+i] ^ full[i+19] ^ full[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '1;
        end else begin
            hist <= serdes_rx_data[DATA_WIDTH-1:DATA_WIDTH-58];
        end
    end
`else
    assign data_next = serdes_rx_data;
`endif

    always_comb begin
        state_next    = state;
        sh_cnt_next   = sh_cnt;
        bad_cnt_next  = bad_cnt;
        hold_cnt_next = hold_cnt;
        bitslip_next  = 1'b0;
        lock_next     = rx_block_lock;
        invalid_next  = 1'b0;

        case (state)
            ST_SEARCH: begin
                lock_next    = 1'b0;
                invalid_next = !hdr_valid;
                if (hdr_valid) begin
                    if (sh_cnt == 6'd63) begin
                        lock_next    = 1'b1;
                        sh_cnt_next  = '0;
                        bad_cnt_next = '0;
                        state_next   = ST_LOCKED;
                    end else begin
                        sh_cnt_next = sh_cnt + 6'd1;
                    end
                end else begin
                    bitslip_next  = 1'b1;
                    sh_cnt_next   = '0;
                    bad_cnt_next  = '0;
                    hold_cnt_next = HOLD_INIT;
                    state_next    = ST_SLIP;
                end
            end

            ST_SLIP: begin
                // Headers are meaningless while the gearbox realigns; just wait.
                lock_next = 1'b0;
                if (hold_cnt <= 8'd1) begin
                    hold_cnt_next = '0;
                    state_next    = ST_SEARCH;
                end else begin
                    hold_cnt_next = hold_cnt - 8'd1;
                end
            end

            ST_LOCKED: begin
                invalid_next = !hdr_valid;
                // Losing lock wins over the window boundary.
                if (!hdr_valid && bad_cnt == 5'd15) begin
                    lock_next     = 1'b0;
                    bitslip_next  = 1'b1;
                    sh_cnt_next   = '0;
                    bad_cnt_next  = '0;
                    hold_cnt_next = HOLD_INIT;
                    state_next    = ST_SLIP;
                end else if (sh_cnt == 6'd63) begin
                    // 64th header closes the window; its result is not carried over.
                    sh_cnt_next  = '0;
                    bad_cnt_next = '0;
                end else begin
                    sh_cnt_next = sh_cnt + 6'd1;
                    if (!hdr_valid) begin
                        bad_cnt_next = bad_cnt + 5'd1;
                    end
                end
            end

            default: begin
                state_next    = ST_SEARCH;
                sh_cnt_next   = '0;
                bad_cnt_next  = '0;
                hold_cnt_next = '0;
                lock_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_SEARCH;
            sh_cnt            <= '0;
            bad_cnt           <= '0;
            hold_cnt          <= '0;
            serdes_rx_bitslip <= 1'b0;
            rx_block_lock     <= 1'b0;
            rx_sh_invalid     <= 1'b0;
            encoded_rx_data   <= '0;
            encoded_rx_hdr    <= '0;
        end else begin
            state             <= state_next;
            sh_cnt            <= sh_cnt_next;
            bad_cnt           <= bad_cnt_next;
            hold_cnt          <= hold_cnt_next;
            serdes_rx_bitslip <= bitslip_next;
            rx_block_lock     <= lock_next;
            rx_sh_invalid     <= invalid_next;
            encoded_rx_data   <= data_next;
            encoded_rx_hdr    <= serdes_rx_hdr;
        end
    end

endmodule

// File: tb/tb_baser_rx_block_sync.sv
// tb/tb_baser_rx_block_sync.sv - self-checking bench for baser_rx_block_sync

module tb_baser_rx_block_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] serdes_rx_data = '0;
    logic [1:0]  serdes_rx_hdr = '0;
    logic        serdes_rx_bitslip;
    logic [63:0] encoded_rx_data;
    logic [1:0]  encoded_rx_hdr;
    logic        rx_block_lock;
    logic        rx_sh_invalid;

    int checks = 0;
    int errors = 0;

    logic [57:0] tx_s;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic        lock;
        logic        slip;
        logic        inv;
    } vec_t;

    vec_t tbl[29];

    baser_rx_block_sync #(
        .DATA_WIDTH(64),
        .HDR_WIDTH (2),
        .SLIP_HOLD (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .serdes_rx_data   (serdes_rx_data),
        .serdes_rx_hdr    (serdes_rx_hdr),
        .serdes_rx_bitslip(serdes_rx_bitslip),
        .encoded_rx_data  (encoded_rx_data),
        .encoded_rx_hdr   (encoded_rx_hdr),
        .rx_block_lock    (rx_block_lock),
        .rx_sh_invalid    (rx_sh_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one header/payload, clock it in, sample 1 ns after the edge.
    task automatic step(input logic [1:0] h, input logic [63:0] d);
        serdes_rx_hdr  = h;
        serdes_rx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lock"}, 64'(rx_block_lock), 64'd0);
        chk({tag, "_slip"}, 64'(serdes_rx_bitslip), 64'd0);
        chk({tag, "_inv"}, 64'(rx_sh_invalid), 64'd0);
        chk({tag, "_hdr"}, 64'(encoded_rx_hdr), 64'd0);
        chk({tag, "_data"}, encoded_rx_data, 64'd0);
    endtask

    // 64 valid headers from SEARCH with sh_cnt==0: lock low through #63, high after #64.
    task automatic lock_up(input string tag);
        int slips;
        slips = 0;
        for (int i = 1; i <= 64; i++) begin
            step(2'b01, 64'(i));
            if (serdes_rx_bitslip) slips++;
            if (i == 63) chk({tag, "_lock_at63"}, 64'(rx_block_lock), 64'd0);
            if (i == 64) chk({tag, "_lock_at64"}, 64'(rx_block_lock), 64'd1);
        end
        chk({tag, "_no_slip"}, 64'(slips), 64'd0);
    endtask

    // Reference 1+x^39+x^58 scrambler; tx_s[0] is the newest scrambled bit.
    task automatic scramble(input logic [63:0] d, output logic [63:0] o);
        logic b;
        for (int i = 0; i < 64; i++) begin
            b = d[i] ^ tx_s[38] ^ tx_s[57];
            o[i] = b;
            tx_s = {tx_s[56:0], b};
        end
    endtask

    initial begin
        int k;
        int slips;
        int invs;
        int drops;
        logic [63:0] blk;

        // Multi-slip sequence from reset: valid, invalid, 8 ignored, 9th checked, ...
        k = 0;
        tbl[k] = '{2'b01, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0}; k++;
        tbl[k] = '{2'b00, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 1'b1}; k++;
        for (int i = 0; i < 8; i++) begin
            tbl[k] = '{2'b11, 64'h1111_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0}; k++;
        end
        tbl[k] = '{2'b11, 64'hDEAD_BEEF_0000_0009, 1'b0, 1'b1, 1'b1}; k++;
        for (int i = 0; i < 8; i++) begin
            tbl[k] = '{2'b10, 64'h2222_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0}; k++;
        end
        tbl[k] = '{2'b00, 64'hCAFE_F00D_0000_0013, 1'b0, 1'b1, 1'b1}; k++;
        for (int i = 0; i < 8; i++) begin
            tbl[k] = '{2'b01, 64'h3333_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0}; k++;
        end
        tbl[k] = '{2'b11, 64'hA5A5_5A5A_A5A5_5A5A, 1'b0, 1'b1, 1'b1}; k++;

        // Reset state
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven slip / hold sequence
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].hdr, tbl[i].data);
            chk($sformatf("tbl%0d_lock", i), 64'(rx_block_lock), 64'(tbl[i].lock));
            chk($sformatf("tbl%0d_slip", i), 64'(serdes_rx_bitslip), 64'(tbl[i].slip));
            chk($sformatf("tbl%0d_inv", i), 64'(rx_sh_invalid), 64'(tbl[i].inv));
            chk($sformatf("tbl%0d_hdr", i), 64'(encoded_rx_hdr), 64'(tbl[i].hdr));
`ifndef BASER_RX_DESCRAMBLE_EN
            chk($sformatf("tbl%0d_data", i), encoded_rx_data, tbl[i].data);
`endif
        end

        // Lock acquisition from reset
        do_reset();
        lock_up("acq");

        // 15 bad in a window holds lock, 16th drops it with one slip
        slips = 0;
        invs = 0;
        for (int i = 1; i <= 15; i++) begin
            step(2'b11, 64'(i));
            if (serdes_rx_bitslip) slips++;
            if (rx_sh_invalid) invs++;
        end
        chk("bad15_lock", 64'(rx_block_lock), 64'd1);
        chk("bad15_slip", 64'(slips), 64'd0);
        chk("bad15_inv", 64'(invs), 64'd15);
        step(2'b11, 64'd16);
        chk("bad16_lock", 64'(rx_block_lock), 64'd0);
        chk("bad16_slip", 64'(serdes_rx_bitslip), 64'd1);
        chk("bad16_inv", 64'(rx_sh_invalid), 64'd1);
        step(2'b01, 64'd17);
        chk("bad16_slip_end", 64'(serdes_rx_bitslip), 64'd0);
        chk("bad16_lock_after", 64'(rx_block_lock), 64'd0);

        // Three windows with 15 bad each (last one at slot 64), then 15 more at
        // the start of the next window: all must hold lock.
        do_reset();
        lock_up("win");
        for (int w = 0; w < 3; w++) begin
            drops = 0;
            for (int s = 1; s <= 64; s++) begin
                step((s >= 50) ? 2'b11 : 2'b01, 64'(s));
                if (!rx_block_lock) drops++;
            end
            chk($sformatf("win%0d_drops", w), 64'(drops), 64'd0);
        end
        for (int s = 1; s <= 15; s++) begin
            step(2'b11, 64'(s));
        end
        chk("win3_bad15_lock", 64'(rx_block_lock), 64'd1);
        step(2'b11, 64'd16);
        chk("win3_bad16_lock", 64'(rx_block_lock), 64'd0);
        chk("win3_bad16_slip", 64'(serdes_rx_bitslip), 64'd1);

        // Async reset while locked with nonzero outputs
        do_reset();
        lock_up("pre_rst");
        step(2'b11, 64'hFFFF_0000_FFFF_0000);
        chk("pre_rst_inv", 64'(rx_sh_invalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        lock_up("post_rst");

        // Async reset in the middle of a slip pulse
        step(2'b01, 64'd1);
        do_reset();
        step(2'b00, 64'd2);
        chk("midslip_slip", 64'(serdes_rx_bitslip), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midslip_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        lock_up("post_slip_rst");

        // Payload path: scrambled idle blocks
        do_reset();
        tx_s = {29{2'b10}};
        for (int b = 0; b < 6; b++) begin
            scramble(64'h0000_0000_0000_001E, blk);
            step(2'b10, blk);
            chk($sformatf("payload%0d_hdr", b), 64'(encoded_rx_hdr), 64'd2);
`ifdef BASER_RX_DESCRAMBLE_EN
            if (b >= 1) chk($sformatf("descr%0d_data", b), encoded_rx_data, 64'h1E);
`else
            chk($sformatf("raw%0d_data", b), encoded_rx_data, blk);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
